// File: rtl/hps_link_master.sv
// ---------------------------------------------------------------------------
// hps_link_master
//   Initiator (HPS-side) end of the 32-bit matrix link. It holds three
//   25-element operand buffers (A, B, C). On cmd_start it pulses the
//   responder reset, holds the start bit, then streams 25 operand words using
//   a ready/ack handshake. After a fixed idle gap it reads 25 result bytes
//   back; a 26th readback handshake closes the transaction.
//
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   op_wr_en/addr/a/b/c     operand buffer write (IDLE only, addr 0..24)
//   cmd_start/opcode/size   transaction start (accepted in IDLE only)
//   busy, done              transaction status / one-cycle end pulse
//   res_valid/index/data    one pulse per captured result byte
//   err                     sticky ack-timeout flag
//   link_out                [31] ready [30] start [29] reset [28:21] C
//                           [20:19] size [18:16] op [15:8] B [7:0] A
//   link_in                 [31] ack, [7:0] result byte
//
// Configuration
//   LINK_TIMEOUT_EN  when defined, every ack wait is bounded by
//                    TIMEOUT_CYCLES; on expiry err is set, the responder
//                    reset bit is pulsed and the transaction ends.
//
// Link handshake: ready (link_out[31]) is raised only while the synchronised
// ack is 0 and stays high until that ack reads 1; ready then drops and the
// next ready waits for the synchronised ack to return to 0. Operand data
// fields change only while both ready and synchronised ack are 0.
// ---------------------------------------------------------------------------
module hps_link_master #(
    parameter int START_HOLD     = 4,
    parameter int PROC_WAIT      = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_wr_en,
    input  logic [4:0]  op_wr_addr,
    input  logic [7:0]  op_wr_a,
    input  logic [7:0]  op_wr_b,
    input  logic [7:0]  op_wr_c,
    input  logic        cmd_start,
    input  logic [2:0]  cmd_opcode,
    input  logic [1:0]  cmd_size,
    output logic        busy,
    output logic        done,
    output logic        res_valid,
    output logic [4:0]  res_index,
    output logic [7:0]  res_data,
    output logic        err,
    output logic [31:0] link_out,
    input  logic [31:0] link_in
);

    localparam int          N_ELEM    = 25;
    localparam logic [31:0] RDY_BIT   = 32'h8000_0000;
    localparam logic [31:0] START_BIT = 32'h4000_0000;
    localparam logic [31:0] RST_BIT   = 32'h2000_0000;

    typedef enum logic [3:0] {
        IDLE, LRST, START, S_ACK, S_REL, PROC, R_ACK, R_REL, DONE
    } state_t;

    state_t                 state;
    logic [7:0]             buf_a [N_ELEM];
    logic [7:0]             buf_b [N_ELEM];
    logic [7:0]             buf_c [N_ELEM];
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic [4:0]             idx;
    logic [4:0]             k;
    logic [31:0]            cnt;
    logic [2:0]             op_q;
    logic [1:0]             size_q;
    logic                   unused_link;

    assign ack_s       = ack_sync[SYNC_STAGES-1];
    assign unused_link = ^link_in[30:8];

    function automatic logic [31:0] operand_word(input logic rdy, input logic [4:0] i);
        return {rdy, 2'b00, buf_c[i], size_q, op_q, buf_b[i], buf_a[i]};
    endfunction

    // Operand buffers: writable only while idle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N_ELEM; i++) begin
                buf_a[i] <= '0;
                buf_b[i] <= '0;
                buf_c[i] <= '0;
            end
        end else if (state == IDLE && op_wr_en && op_wr_addr <= 5'd24) begin
            buf_a[op_wr_addr] <= op_wr_a;
            buf_b[op_wr_addr] <= op_wr_b;
            buf_c[op_wr_addr] <= op_wr_c;
        end
    end

    // Ack synchroniser.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ack_sync <= '0;
        end else begin
            ack_sync[0] <= link_in[31];
            for (int i = 1; i < SYNC_STAGES; i++) ack_sync[i] <= ack_sync[i-1];
        end
    end

`ifdef LINK_TIMEOUT_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            link_out  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            res_valid <= 1'b0;
            res_index <= '0;
            res_data  <= '0;
            idx       <= '0;
            k         <= '0;
            cnt       <= '0;
            op_q      <= '0;
            size_q    <= '0;
`ifdef LINK_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
        end else begin
            done      <= 1'b0;
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    busy     <= 1'b0;
                    link_out <= '0;
                    if (cmd_start) begin
                        op_q     <= cmd_opcode;
                        size_q   <= cmd_size;
                        busy     <= 1'b1;
                        idx      <= '0;
                        k        <= '0;
                        cnt      <= '0;
                        link_out <= RST_BIT;
                        state    <= LRST;
`ifdef LINK_TIMEOUT_EN
                        err_q    <= 1'b0;
`endif
                    end
                end
                LRST: begin
                    cnt <= '0;
                    if (START_HOLD == 0) begin
                        link_out <= operand_word(1'b0, idx);
                        state    <= S_ACK;
                    end else begin
                        link_out <= START_BIT;
                        state    <= START;
                    end
                end
                START: begin
                    if (cnt == 32'(START_HOLD - 1)) begin
                        cnt      <= '0;
                        link_out <= operand_word(1'b0, idx);
                        state    <= S_ACK;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_ACK: begin
                    if (link_out[31] && ack_s) begin
                        link_out[31] <= 1'b0;
                        cnt          <= '0;
                        state        <= S_REL;
                    end else begin
                        // Covers a stale ack still high on entry: wait for it to fall.
                        if (!ack_s) link_out[31] <= 1'b1;
                        cnt <= cnt + 32'd1;
                    end
                end
                S_REL: begin
                    if (!ack_s) begin
                        cnt <= '0;
                        if (idx == 5'd24) begin
                            k <= 5'd1;
                            if (PROC_WAIT == 0) begin
                                link_out <= RDY_BIT;
                                state    <= R_ACK;
                            end else begin
                                link_out <= '0;
                                state    <= PROC;
                            end
                        end else begin
                            idx      <= idx + 5'd1;
                            link_out <= operand_word(1'b0, idx + 5'd1);
                            state    <= S_ACK;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                PROC: begin
                    if (cnt == 32'(PROC_WAIT - 1)) begin
                        cnt   <= '0;
                        state <= R_ACK;
                        if (!ack_s) link_out <= RDY_BIT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                R_ACK: begin
                    if (link_out[31] && ack_s) begin
                        link_out[31] <= 1'b0;
                        cnt          <= '0;
                        state        <= R_REL;
                        // Handshake 26 only closes the readback; it carries no result.
                        if (k <= 5'd25) begin
                            res_valid <= 1'b1;
                            res_data  <= link_in[7:0];
                            res_index <= k - 5'd1;
                        end
                    end else begin
                        if (!ack_s) link_out[31] <= 1'b1;
                        cnt <= cnt + 32'd1;
                    end
                end
                R_REL: begin
                    if (!ack_s) begin
                        cnt <= '0;
                        if (k == 5'd26) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            k        <= k + 5'd1;
                            link_out <= RDY_BIT;
                            state    <= R_ACK;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                DONE: begin
                    link_out <= '0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef LINK_TIMEOUT_EN
            // Overrides whatever the wait state decided this cycle.
            if ((state == S_ACK || state == S_REL || state == R_ACK || state == R_REL)
                && cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                err_q     <= 1'b1;
                link_out  <= RST_BIT;
                done      <= 1'b1;
                res_valid <= 1'b0;
                cnt       <= '0;
                state     <= DONE;
            end
`endif
        end
    end

endmodule
